// File: rtl/inst_prefetch.sv
// Instruction prefetch queue: credit-limited fetch issue, in-order response queue, redirect with stale drain.
// Optional PREFETCH_BYPASS_EN: a response arriving at an empty queue is presented to decode in the same cycle.
module inst_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic          started;
  logic [31:0]   fpc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] stale;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] stale_nxt;
  logic [CW:0]   credit_sum;

  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   a_addr [DEPTH];
  logic [PW-1:0] q_wr, q_rd, a_wr, a_rd;

  logic accept;
  logic rsp_ok;
  logic push;
  logic pop;
  logic bypass_take;

  // Handshakes: a fetch transfers when imem_req & imem_ready at a rising edge; a decoded
  // instruction transfers when inst_valid & inst_ready. Redirect overrides both that cycle.
  assign credit_sum = {1'b0, count} + {1'b0, outstanding};
  assign imem_req   = started && (state == RUN) && !redirect &&
                      (credit_sum < (CW+1)'(DEPTH));
  assign imem_addr  = fpc;
  assign accept     = imem_req & imem_ready;

  // Outside RUN every response belongs to a request issued before the last redirect.
  assign rsp_ok  = started && imem_rvalid && (state == RUN) && !redirect;
  assign out_nxt = outstanding + CW'(accept) - CW'(imem_rvalid);

`ifdef PREFETCH_BYPASS_EN
  logic byp;
  assign byp         = rsp_ok && (count == '0);
  assign inst_valid  = (count != '0) || byp;
  assign inst        = (count != '0) ? q_data[q_rd] : (byp ? imem_rdata   : '0);
  assign inst_pc     = (count != '0) ? q_pc[q_rd]   : (byp ? a_addr[a_rd] : '0);
  assign bypass_take = byp && inst_ready;
`else
  assign inst_valid  = (count != '0);
  assign inst        = inst_valid ? q_data[q_rd] : '0;
  assign inst_pc     = inst_valid ? q_pc[q_rd]   : '0;
  assign bypass_take = 1'b0;
`endif

  assign push      = rsp_ok && !bypass_take;
  assign pop       = (count != '0) && inst_ready && !redirect;
  assign dbg_state = (state == DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Stale counts responses still owed for requests issued before the latest redirect.
  always_comb begin
    state_nxt = state;
    stale_nxt = stale;
    if (redirect) begin
      stale_nxt = out_nxt;
      state_nxt = (out_nxt != '0) ? DRAIN : RUN;
    end else if (state == DRAIN) begin
      if (imem_rvalid) begin
        stale_nxt = stale - CW'(1);
      end
      if (stale_nxt == '0) begin
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started     <= 1'b0;
      stale       <= '0;
      outstanding <= '0;
      fpc         <= RESET_PC;
      count       <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      a_wr        <= '0;
      a_rd        <= '0;
    end else begin
      started     <= 1'b1;
      stale       <= stale_nxt;
      outstanding <= out_nxt;
      if (redirect) begin
        fpc   <= redirect_pc;
        count <= '0;
        q_wr  <= '0;
        q_rd  <= '0;
        a_wr  <= '0;
        a_rd  <= '0;
      end else begin
        if (accept) begin
          fpc <= fpc + 32'd4;
        end
        count <= count + CW'(push) - CW'(pop);
        q_wr  <= q_wr + PW'(push);
        q_rd  <= q_rd + PW'(pop);
        a_wr  <= a_wr + PW'(accept);
        a_rd  <= a_rd + PW'(rsp_ok);
      end
    end
  end

  // Storage needs no reset: outputs are masked by inst_valid and pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[q_wr] <= imem_rdata;
      q_pc[q_wr]   <= a_addr[a_rd];
    end
    if (accept) begin
      a_addr[a_wr] <= fpc;
    end
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Randomized bench for inst_prefetch: in-order memory model plus a request-list reference model.
module tb_inst_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic        clk;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready  = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready  = 1'b0;
  logic        dbg_state;

  inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .dbg_state  (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: decoded-instruction queue, issued-request list, fetch pointer
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mem_t;

  logic [63:0] exp_q[$];
  pend_t       pend_q[$];
  mem_t        mem_q[$];
  logic [31:0] m_fpc       = RESET_PC;
  bit          m_started   = 1'b0;
  int          cyc         = 0;
  int          dut_accepts = 0;
  int          mem_lat_max = 2;

  function automatic bit m_drain();
    foreach (pend_q[i]) if (pend_q[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pick_pc();
    int sel = int'($urandom_range(0, 3));
    if (sel == 0) return 32'h00000100;
    if (sel == 1) return 32'hFFFFFFFC;
    return $urandom() & 32'hFFFFFFFC;
  endfunction

  task automatic apply_reset();
    rst         = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    inst_ready  = 1'b0;
    #1;
    check_val("rst_imem_req",   32'(imem_req),   32'd0);
    check_val("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_val("rst_inst",       inst,            32'd0);
    check_val("rst_inst_pc",    inst_pc,         32'd0);
    check_val("rst_imem_addr",  imem_addr,       RESET_PC);
    check_val("rst_state",      32'(dbg_state),  32'd0);
    exp_q.delete();
    pend_q.delete();
    mem_q.delete();
    m_fpc     = RESET_PC;
    m_started = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rel_imem_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    m_started = 1'b1;
  endtask

  // driver: one cycle of stimulus, checks, memory and model update
  task automatic one_cycle(input int p_ready, input int p_iready, input int p_redir,
                           input logic [31:0] rpc);
    bit          rv, byp, exp_req, drain, acc_m, acc_d, redir, iready;
    logic [31:0] rdata;
    logic [63:0] head;
    pend_t       r;
    @(negedge clk);
    imem_ready  = (int'($urandom_range(0, 99)) < p_ready);
    rv          = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rdata       = rv ? mem_q[0].data : $urandom();
    imem_rvalid = rv;
    imem_rdata  = rdata;
    iready      = (int'($urandom_range(0, 99)) < p_iready);
    redir       = (int'($urandom_range(0, 99)) < p_redir);
    inst_ready  = iready;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    drain   = m_drain();
    exp_req = m_started && !drain && !redir && ((exp_q.size() + pend_q.size()) < DEPTH);
    byp     = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    byp = m_started && rv && !redir && !drain && (exp_q.size() == 0) && (pend_q.size() > 0);
`endif
    check_val("imem_req",   32'(imem_req),   32'(exp_req));
    check_val("imem_addr",  imem_addr,       m_fpc);
    check_val("drain",      32'(dbg_state),  32'(drain));
    check_val("inst_valid", 32'(inst_valid), 32'((exp_q.size() != 0) || byp));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check_val("inst",    inst,    head[63:32]);
      check_val("inst_pc", inst_pc, head[31:0]);
    end else if (byp) begin
      check_val("byp_inst",    inst,    rdata);
      check_val("byp_inst_pc", inst_pc, pend_q[0].addr);
    end
    acc_d = imem_req && imem_ready;
    acc_m = exp_req && imem_ready;
    @(posedge clk);
    if (rv) void'(mem_q.pop_front());
    if (acc_d) begin
      mem_q.push_back('{data: $urandom(), due: cyc + 1 + int'($urandom_range(0, mem_lat_max))});
      dut_accepts++;
    end
    if (!redir && iready && (exp_q.size() != 0)) void'(exp_q.pop_front());
    if (rv && (pend_q.size() > 0)) begin
      r = pend_q.pop_front();
      if (!redir && !r.stale && !(byp && iready)) exp_q.push_back({rdata, r.addr});
    end
    if (redir) begin
      exp_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      m_fpc = rpc;
    end else if (acc_m) begin
      pend_q.push_back('{addr: m_fpc, stale: 1'b0});
      m_fpc = m_fpc + 32'd4;
    end
    cyc++;
  endtask

  task automatic build_outstanding(input int want);
    int n = 0;
    while ((pend_q.size() < want) && (n < 50)) begin
      one_cycle(100, 100, 0, 32'h0);
      n++;
    end
    check_val("outstanding_reached", 32'(pend_q.size() >= want), 32'd1);
  endtask

  initial begin
    #2;
    apply_reset();

    // straight-line streaming from reset
    repeat (30) one_cycle(100, 100, 0, 32'h0);

    // decode stalled: credits limit issue to DEPTH requests
    #2;
    apply_reset();
    dut_accepts = 0;
    repeat (20) one_cycle(100, 0, 0, 32'h0);
    check_val("stall_accepts", 32'(dut_accepts), 32'(DEPTH));
    repeat (10) one_cycle(100, 100, 0, 32'h0);

    // redirect with several requests in flight
    mem_lat_max = 6;
    build_outstanding(3);
    one_cycle(100, 100, 100, 32'h00000100);
    repeat (25) one_cycle(100, 100, 0, 32'h0);

    // fetch address wrap
    one_cycle(100, 100, 100, 32'hFFFFFFFC);
    repeat (15) one_cycle(100, 100, 0, 32'h0);

    // random mix: redirects racing responses and pops
    mem_lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      one_cycle(70, 60, 5, pick_pc());
    end

    // reset while draining
    mem_lat_max = 6;
    build_outstanding(2);
    one_cycle(100, 100, 100, 32'h00000200);
    @(negedge clk);
    #1;
    check_val("pre_reset_drain", 32'(dbg_state), 32'd1);
    apply_reset();
    mem_lat_max = 2;
    repeat (30) one_cycle(80, 70, 3, pick_pc());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries and the outstanding-fetch limit (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning an asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  meaning a fetch request is valid.
REQ-006 SHALL have port imem_addr  output  32  meaning the byte address of the requested word.
REQ-007 SHALL have port imem_ready  input  1  meaning the memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  meaning response data is valid; responses return in order, at least 1 cycle after acceptance.
REQ-009 SHALL have port imem_rdata  input  32  meaning the instruction word of the response.
REQ-010 SHALL have port redirect  input  1  meaning a branch was taken or the pipeline is flushing.
REQ-011 SHALL have port redirect_pc  input  32  meaning the new fetch address when redirect is high.
REQ-012 SHALL have port inst_valid  output  1  meaning inst and inst_pc are valid toward decode.
REQ-013 SHALL have port inst  output  32  meaning the instruction word toward decode.
REQ-014 SHALL have port inst_pc  output  32  meaning the address of inst.
REQ-015 SHALL have port inst_ready  input  1  meaning decode consumes the head entry this cycle.

Function
REQ-016 SHALL hold the fetch PC (fpc) and drive imem_addr = fpc; an accepted request (imem_req & imem_ready) advances fpc by 4, wrapping modulo 2^32.
REQ-017 SHALL assert imem_req only in state RUN and only when count + outstanding < DEPTH; this credit rule guarantees that the queue never overflows.
REQ-018 SHALL track outstanding: +1 on acceptance, -1 on imem_rvalid, both in the same cycle = unchanged.
REQ-019 SHALL push {imem_rdata, pc} into the queue on a non-stale imem_rvalid, where pc is the queued address of that request; the issued addresses SHALL be kept in a parallel DEPTH-entry address FIFO.
REQ-020 SHALL pop the head on inst_valid & inst_ready; push and pop in the same cycle are both allowed at any occupancy.
REQ-021 SHALL drive inst_valid = (count != 0), with inst and inst_pc taken from the head; the head SHALL stay stable while inst_valid & ~inst_ready.
REQ-022 SHALL implement the FSM states RUN and DRAIN: redirect -> DRAIN if outstanding (after this cycle's updates) is nonzero, else RUN; DRAIN -> RUN when stale reaches 0.
REQ-023 SHALL, on redirect: empty the queue and address FIFO, set fpc = redirect_pc, set stale = outstanding excluding a same-cycle response, and suppress imem_req that cycle.
REQ-024 SHALL, in DRAIN, discard every imem_rvalid and decrement stale, issuing no requests.
REQ-025 SHALL give redirect priority over same-cycle pop, push and acceptance: the response is treated as stale and inst_ready is ignored.
REQ-026 SHALL, on redirect while in DRAIN, set stale to all outstanding and reload fpc.
REQ-027 SHALL have a latency of 1 cycle from imem_rvalid into an empty queue to inst_valid.

Reset
REQ-028 SHALL, while rst=0 (asynchronous): fpc=RESET_PC, count=0, outstanding=0, stale=0, state=RUN, imem_req=0, inst_valid=0, inst=0, inst_pc=0.
REQ-029 SHALL assert the first imem_req on the first clock edge after rst deasserts; responses from before reset are the memory's responsibility.

Configuration
REQ-030 SHALL, when the macro PREFETCH_BYPASS_EN is defined, present a non-stale imem_rvalid combinationally on inst/inst_pc/inst_valid in the same cycle if the queue is empty, and not enqueue it if inst_ready is high; latency becomes 0 cycles.
REQ-031 SHALL, when PREFETCH_BYPASS_EN is undefined, have no combinational path from imem_* to inst_*, giving the latency of REQ-027.

Verification
REQ-032 SHALL cover reset release with imem_ready=1, rvalid 1 cycle later, inst_ready=1 -> imem_addr 0,4,8,...; inst_pc 0,4,8 with inst matching rdata in order.
REQ-033 SHALL cover inst_ready=0 with DEPTH=4 -> exactly 4 requests accepted (addr 0..12), count=4, imem_req=0 until a pop, then one new request at addr 16.
REQ-034 SHALL cover redirect to 32'h100 with 3 outstanding -> DRAIN, 3 responses discarded, inst_valid=0, then request at 32'h100 and first inst_pc=32'h100.
REQ-035 SHALL cover redirect in the same cycle as imem_rvalid and inst_ready -> response dropped, queue empty next cycle, stale equals the remaining outstanding.
REQ-036 SHALL cover redirect_pc=32'hFFFFFFFC -> next addresses are FFFFFFFC then 00000000.
REQ-037 SHALL cover rst=0 asserted mid-DRAIN -> all outputs are at reset values immediately, with no clock edge needed.
